// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer between prog_memory and the decoder: assembles
// one/two-word instructions, resolves RJMP/JMP locally and applies redirects.
module fetch_ctrl #(
  parameter int PC_W = 14,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IW-1:0]   instruction,
  input  logic [PC_W-1:0] program_counter,
  output logic            PC_inc,
  output logic            hold,
  output logic            PC_overwrite,
  output logic [PC_W-1:0] PC_new,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [IW-1:0]   dec_instr,
  output logic [IW-1:0]   dec_op2,
  output logic            dec_two_word,
  output logic [PC_W-1:0] dec_pc,
  input  logic            redir_req,
  input  logic [PC_W-1:0] redir_addr
);

  typedef enum logic [1:0] {S_BOOT, S_FLUSH, S_RUN, S_OP2} state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] fpc;
  logic [PC_W-1:0] op1_pc;
  logic [IW-1:0]   op1;

  logic              redirect;
  logic              cur_two_word;
  logic              cur_rjmp;
  logic              op1_jmp;
  logic signed [11:0] rjmp_k;
  logic [PC_W-1:0]   rjmp_target;

  function automatic logic is_jmp(input logic [IW-1:0] w);
    return (w[15:9] == 7'b1001010) && (w[3:1] == 3'b110);
  endfunction

  function automatic logic is_two_word(input logic [IW-1:0] w);
    logic jmp_call;
    logic lds_sts;
    jmp_call = (w[15:9] == 7'b1001010) && (w[3:2] == 2'b11);
    lds_sts  = (w[15:10] == 6'b100100) && (w[3:0] == 4'b0000);
    return jmp_call || lds_sts;
  endfunction

  assign redirect     = redir_req && (state != S_BOOT);
  assign cur_two_word = is_two_word(instruction);
  assign cur_rjmp     = (instruction[15:12] == 4'b1100);
  assign op1_jmp      = is_jmp(op1);
  assign rjmp_k       = instruction[11:0];
  // Sized cast of the signed offset sign-extends; the sum wraps mod 2^PC_W.
  assign rjmp_target  = fpc + PC_W'(1) + PC_W'(rjmp_k);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fpc    <= '0;
      op1    <= '0;
      op1_pc <= '0;
    end else begin
      if (PC_inc && !hold && !PC_overwrite) begin
        fpc <= program_counter;
      end
      if (state == S_RUN && !redirect && cur_two_word) begin
        op1    <= instruction;
        op1_pc <= fpc;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_BOOT:  state_next = S_FLUSH;
      S_FLUSH: state_next = S_RUN;
      S_RUN: begin
        if (cur_two_word) begin
          state_next = S_OP2;
        end else if (cur_rjmp) begin
          state_next = S_FLUSH;
        end
      end
      S_OP2: begin
        if (op1_jmp) begin
          state_next = S_FLUSH;
        end else if (dec_ready) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_BOOT;
    endcase
    if (redirect) begin
      state_next = S_FLUSH;
    end
  end

  always_comb begin
    PC_inc       = 1'b0;
    hold         = 1'b0;
    PC_overwrite = 1'b0;
    PC_new       = '0;
    dec_valid    = 1'b0;
    dec_instr    = '0;
    dec_op2      = '0;
    dec_two_word = 1'b0;
    dec_pc       = '0;
    unique case (state)
      S_BOOT: ;
      S_FLUSH: PC_inc = 1'b1;
      S_RUN: begin
        if (cur_two_word) begin
          PC_inc = 1'b1;
        end else if (cur_rjmp) begin
          PC_overwrite = 1'b1;
          PC_new       = rjmp_target;
        end else begin
          dec_valid = 1'b1;
          dec_instr = instruction;
          dec_pc    = fpc;
          PC_inc    = dec_ready;
          hold      = !dec_ready;
        end
      end
      S_OP2: begin
        if (op1_jmp) begin
          PC_overwrite = 1'b1;
          PC_new       = instruction[PC_W-1:0];
        end else begin
          dec_valid    = 1'b1;
          dec_two_word = 1'b1;
          dec_instr    = op1;
          dec_op2      = instruction;
          dec_pc       = op1_pc;
          PC_inc       = dec_ready;
          hold         = !dec_ready;
        end
      end
      default: ;
    endcase
    if (redirect) begin
      PC_inc       = 1'b0;
      hold         = 1'b0;
      PC_overwrite = 1'b1;
      PC_new       = redir_addr;
      dec_valid    = 1'b0;
      dec_instr    = '0;
      dec_op2      = '0;
      dec_two_word = 1'b0;
      dec_pc       = '0;
    end
  end

endmodule
